io_uart_tx: RTL and testbench



---
 rtl/io_defs.sv | 20 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/io_uart_tx.sv | 152 +++++++++++++++
 tb/tb_io_uart_tx.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_defs.sv
// Shared definitions for the I/O UART transmitter.
// Holds the FSM state encoding, 8N1 frame constants and the default bit period.
package io_defs;

  // Transmit FSM state encoding (2-bit)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // 8N1 frame constants
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count/full/empty status.
// Ports:
//   clk, sync_reset : clock and synchronous active-high reset
//   push, push_data : write strobe and data (ignored when full)
//   pop             : remove head entry (ignored when empty)
//   head_c          : current head entry (combinational read of storage)
//   count           : entries held, 0..DEPTH
//   full, empty     : registered status flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     sync_reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_d;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count_d = count + CW'(do_push) - CW'(do_pop);
  assign head_c  = mem[rd_ptr];

  // Storage; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// CPU I/O-port byte transmitter: buffers written bytes in a FIFO and sends
// them as 8N1 UART frames, back-to-back when more data is queued.
// Ports:
//   clk, sync_reset : clock and synchronous active-high reset
//   io_data_in      : byte from the CPU
//   io_write        : one-cycle write strobe (dropped when FIFO full)
//   overflow_clr    : clears the sticky overflow flag
//   tx              : registered UART line, idle high
//   busy            : frame in progress
//   fifo_empty/fifo_full/fifo_count : FIFO status
//   overflow        : sticky, a write was dropped
module io_uart_tx
  import io_defs::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                          clk,
  input  logic                          sync_reset,
  input  logic [7:0]                    io_data_in,
  input  logic                          io_write,
  input  logic                          overflow_clr,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned BIT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  uart_state_e      state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shifter_q;
  logic [7:0]       fifo_head_c;
  logic             pop_c;
  logic             bit_end_c;
  logic             tx_d;
  logic             busy_d;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .sync_reset (sync_reset),
    .push       (io_write),
    .push_data  (io_data_in),
    .pop        (pop_c),
    .head_c     (fifo_head_c),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign bit_end_c = (bit_cnt_q == BIT_W'(CLKS_PER_BIT - 1));

  // State register, frame counters and registered line outputs
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      tx        <= tx_d;
      busy      <= busy_d;
    end
  end

  // Shifter holds the byte for the whole frame; loaded on every pop
  always_ff @(posedge clk) begin
    if (pop_c) shifter_q <= fifo_head_c;
  end

  // Next-state logic; pops occur only when a new frame is started
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    pop_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          state_d   = ST_START;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (bit_end_c) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          idx_d     = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          bit_cnt_d = '0;
          if (idx_q == IDX_W'(DATA_BITS - 1)) state_d = ST_STOP;
          else                                idx_d   = idx_q + IDX_W'(1);
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          bit_cnt_d = '0;
          // Chain straight into the next start bit when data is waiting
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line value for the upcoming state, registered above so tx has no input path
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START: tx_d = START_BIT;
      ST_DATA:  tx_d = shifter_q[idx_d];
      ST_STOP:  tx_d = STOP_BIT;
      default:  tx_d = 1'b1;
    endcase
  end

  // Sticky overflow: a dropped write wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (sync_reset)                  overflow <= 1'b0;
    else if (io_write && fifo_full)  overflow <= 1'b1;
    else if (overflow_clr)           overflow <= 1'b0;
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: frame-level reference model compared
// every cycle, a line decoder checking received byte order, and literal
// expectations for the directed scenarios.
module tb_io_uart_tx;

  localparam int unsigned D = 8;
  localparam int unsigned C = 4;

  logic       clk;
  logic       sync_reset;
  logic [7:0] io_data_in;
  logic       io_write;
  logic       overflow_clr;
  logic       tx;
  logic       busy;
  logic       fifo_empty;
  logic       fifo_full;
  logic [3:0] fifo_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  io_uart_tx #(
    .FIFO_DEPTH   (D),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .io_data_in   (io_data_in),
    .io_write     (io_write),
    .overflow_clr (overflow_clr),
    .tx           (tx),
    .busy         (busy),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame position arithmetic) ----------
  logic [7:0] m_q[$];
  logic       m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_valid = 1'b0;
  int         rst_cnt = 0;

  always @(posedge clk) begin
    logic pre_full, pre_empty;
    if (sync_reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
      m_valid  = 1'b1;
      rst_cnt++;
    end else if (m_valid) begin
      pre_full  = (m_q.size() == D);
      pre_empty = (m_q.size() == 0);
      if (m_active) begin
        m_t++;
        if (m_t == 10 * C) begin
          if (!pre_empty) begin
            m_byte = m_q.pop_front();
            m_t    = 0;
          end else begin
            m_active = 1'b0;
          end
        end
      end else if (!pre_empty) begin
        m_byte   = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (io_write && !pre_full) m_q.push_back(io_data_in);
      if (io_write && pre_full)  m_ovf = 1'b1;
      else if (overflow_clr)     m_ovf = 1'b0;
    end
  end

  function automatic logic exp_tx();
    if (!m_active)         return 1'b1;
    if (m_t < int'(C))     return 1'b0;
    if (m_t < int'(9 * C)) return m_byte[(m_t / C) - 1];
    return 1'b1;
  endfunction

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_tx",       32'(tx),         32'(exp_tx()));
      chk("model_busy",     32'(busy),       32'(m_active));
      chk("model_count",    32'(fifo_count), 32'(m_q.size()));
      chk("model_empty",    32'(fifo_empty), 32'(m_q.size() == 0));
      chk("model_full",     32'(fifo_full),  32'(m_q.size() == D));
      chk("model_overflow", 32'(overflow),   32'(m_ovf));
    end
  end

  // ---------------- line decoder ----------------
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];

  initial begin : rx_decoder
    logic       prev;
    logic [7:0] b;
    int         start_rst;
    prev = 1'b1;
    b    = 8'h00;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx === 1'b0 && sync_reset === 1'b0) begin
        start_rst = rst_cnt;
        repeat (C / 2) @(negedge clk);
        if (start_rst == rst_cnt) chk("rx_start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = tx;
        end
        repeat (C) @(negedge clk);
        if (start_rst == rst_cnt) begin
          chk("rx_stop_bit", 32'(tx), 32'd1);
          rx_q.push_back(b);
        end
      end
      prev = tx;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b);
    io_write   = 1'b1;
    io_data_in = b;
    tick();
    io_write   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || !fifo_empty) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(busy || !fifo_empty), 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_rx(input string name);
    chk($sformatf("%s_len", name), 32'(rx_q.size()), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_rx[i]));
    rx_q.delete();
    exp_rx.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic exp_seq[10];
    int   n;
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    sync_reset   = 1'b1;
    io_write     = 1'b0;
    io_data_in   = 8'h00;
    overflow_clr = 1'b0;
    repeat (2) tick();
    chk("rst_tx",    32'(tx),         32'd1);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full",  32'(fifo_full),  32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf",   32'(overflow),   32'd0);
    sync_reset = 1'b0;
    repeat (2) tick();

    // Single byte 0xA5 written at edge 0
    wr(8'hA5);
    chk("a5_count_e0", 32'(fifo_count), 32'd1);
    chk("a5_busy_e0",  32'(busy),       32'd0);
    tick();
    chk("a5_busy_e1",  32'(busy),       32'd1);
    chk("a5_count_e1", 32'(fifo_count), 32'd0);
    chk("a5_tx_e1",    32'(tx),         32'd0);
    tick();
    chk("a5_bit0", 32'(tx), 32'(exp_seq[0]));
    for (int k = 1; k < 10; k++) begin
      repeat (4) tick();
      chk($sformatf("a5_bit%0d", k), 32'(tx), 32'(exp_seq[k]));
    end
    repeat (2) tick();
    chk("a5_busy_last_stop", 32'(busy), 32'd1);
    tick();
    chk("a5_busy_end",  32'(busy),       32'd0);
    chk("a5_empty_end", 32'(fifo_empty), 32'd1);
    repeat (3) tick();
    exp_rx.push_back(8'hA5);
    check_rx("a5_rx");

    // Back-to-back 0x00, 0xFF: 20 contiguous bit periods
    wr(8'h00);
    wr(8'hFF);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk("b2b_busy_cycles", 32'(n), 32'd80);
    chk("b2b_tx_idle",     32'(tx), 32'd1);
    repeat (3) tick();
    exp_rx.push_back(8'h00);
    exp_rx.push_back(8'hFF);
    check_rx("b2b_rx");

    // Overflow: 10 consecutive writes into an 8-deep FIFO
    for (int i = 1; i <= 10; i++) wr(8'(i));
    chk("ovf_full",  32'(fifo_full), 32'd1);
    chk("ovf_set",   32'(overflow),  32'd1);
    chk("ovf_count", 32'(fifo_count), 32'd8);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    drain();
    for (int i = 1; i <= 9; i++) exp_rx.push_back(8'(i));
    check_rx("ovf_rx");

    // Clear coincident with a dropped write: set wins
    for (int i = 0; i < 10; i++) wr(8'(8'hB1 + i));
    chk("coinc_ovf_pre", 32'(overflow), 32'd1);
    io_write     = 1'b1;
    io_data_in   = 8'hBB;
    overflow_clr = 1'b1;
    tick();
    io_write     = 1'b0;
    overflow_clr = 1'b0;
    chk("coinc_ovf_kept", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("coinc_ovf_clr", 32'(overflow), 32'd0);
    drain();
    for (int i = 0; i < 9; i++) exp_rx.push_back(8'(8'hB1 + i));
    check_rx("coinc_rx");

    // Reset during the DATA state of 0x3C with 3 bytes queued
    wr(8'h3C);
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    chk("rstm_count_pre", 32'(fifo_count), 32'd3);
    repeat (6) tick();
    chk("rstm_busy_pre", 32'(busy), 32'd1);
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    chk("rstm_tx",    32'(tx),         32'd1);
    chk("rstm_busy",  32'(busy),       32'd0);
    chk("rstm_count", 32'(fifo_count), 32'd0);
    repeat (100) tick();
    chk("rstm_nothing_sent", 32'(rx_q.size()), 32'd0);
    chk("rstm_still_idle",   32'(busy),        32'd0);
    rx_q.delete();

    // Pointer wrap: 20 bytes with gaps, FIFO never fills
    for (int i = 0; i < 20; i++) begin
      wr(8'(i * 37 + 5));
      exp_rx.push_back(8'(i * 37 + 5));
      repeat (29) tick();
    end
    drain();
    chk("wrap_no_ovf", 32'(overflow), 32'd0);
    check_rx("wrap_rx");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
